// File: rtl/mul_seq_32_pkg.sv
// mul_seq_32_pkg: shared ALU constants and multiplier state encodings
package mul_seq_32_pkg;
    localparam int ALU_WIDTH = 32;
    localparam int MUL_ITERS = 32;
    localparam int MUL_CNT_W = $clog2(MUL_ITERS);
    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;
endpackage

// File: rtl/mul_seq_32_adder.sv
// adder_32: combinational 32-bit adder with carry in/out
module adder_32
    import mul_seq_32_pkg::*;
(
    output logic [ALU_WIDTH-1:0] s,
    output logic                 c_out,
    input  logic [ALU_WIDTH-1:0] a,
    input  logic [ALU_WIDTH-1:0] b,
    input  logic                 c_in
);
    assign {c_out, s} = {1'b0, a} + {1'b0, b} + {{ALU_WIDTH{1'b0}}, c_in};
endmodule

// File: rtl/mul_seq_32.sv
// mul_seq_32: sequential shift-and-add 32x32->64 multiplier; MUL_ZERO_SKIP_EN finishes zero operands in one cycle
module mul_seq_32
    import mul_seq_32_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);
    mul_state_t state, state_nxt;
    logic [WIDTH-1:0] mcand, hi, lo, s, add_b;
    logic [CNT_W-1:0] count;
    logic c_out, last, accept, skip;
    adder_32 u_add (.s(s), .c_out(c_out), .a(hi), .b(add_b), .c_in(1'b0));
    always_comb begin
        add_b = lo[0] ? mcand : '0;
        last = count == CNT_W'(MUL_ITERS - 1);
        accept = start && state != MUL_RUN;
`ifdef MUL_ZERO_SKIP_EN
        skip = a == '0 || b == '0;
`else
        skip = 1'b0;
`endif
        state_nxt = state == MUL_RUN ? (last ? MUL_DONE : MUL_RUN)
                  : accept ? (skip ? MUL_DONE : MUL_RUN) : MUL_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MUL_IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
            p     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mcand <= a;
                hi    <= '0;
                lo    <= b;
                count <= '0;
                if (skip) p <= '0;
            end else if (state == MUL_RUN) begin
                {hi, lo} <= {c_out, s, lo[WIDTH-1:1]};
                count    <= count + 1'b1;
                if (last) p <= {c_out, s, lo[WIDTH-1:1]};
            end
        end
    end
    assign busy = state == MUL_RUN;
    assign done = state == MUL_DONE;
endmodule
